// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared writeback-source codes and hazard controller FSM encoding
package cpu_defs;

  localparam logic [3:0] WB_ALU = 4'b0001;
  localparam logic [3:0] WB_LO  = 4'b0010;
  localparam logic [3:0] WB_HI  = 4'b0100;
  localparam logic [3:0] WB_CP0 = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DIV   = 2'b01,
    ST_MWAIT = 2'b10
  } state_t;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational ID-stage hazards the forwarding network cannot cover
module hazard_detect
  import cpu_defs::*;
(
  input  logic [1:0] bj_id,
  input  logic [1:0] use_id,
  input  logic [4:0] r1_id,
  input  logic [4:0] r2_id,
  input  logic [4:0] rw_ex,
  input  logic [4:0] rw_mem,
  input  logic [3:0] reg_we_direct_ex,
  input  logic       mem_read_ex,
  input  logic       mem_read_mem,
  output logic       h_bj_ex,
  output logic       h_bj_mem,
  output logic       h_lu
);

  logic rs_ex, rt_ex, rs_mem, rt_mem;

  // $0 is never a real producer, so a zero destination never matches
  assign rs_ex  = (rw_ex != 5'd0) && (r1_id == rw_ex);
  assign rt_ex  = (rw_ex != 5'd0) && (r2_id == rw_ex);
  assign rs_mem = (rw_mem != 5'd0) && (r1_id == rw_mem);
  assign rt_mem = (rw_mem != 5'd0) && (r2_id == rw_mem);

  assign h_bj_ex  = ((bj_id[0] && rs_ex) || (bj_id[1] && rt_ex)) && (reg_we_direct_ex == WB_ALU);
  assign h_bj_mem = ((bj_id[0] && rs_mem) || (bj_id[1] && rt_mem)) && mem_read_mem;
  assign h_lu     = ((use_id[0] && rs_ex) || (use_id[1] && rt_ex)) && mem_read_ex;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush scheduler with divide and SRAM-wait sequencing
module pipe_hazard_ctrl
  import cpu_defs::*;
#(
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [1:0]       bj_id,
  input  logic [1:0]       use_id,
  input  logic [4:0]       r1_id,
  input  logic [4:0]       r2_id,
  input  logic [4:0]       rw_ex,
  input  logic [4:0]       rw_mem,
  input  logic [3:0]       reg_we_direct_ex,
  input  logic             mem_read_ex,
  input  logic             mem_read_mem,
  input  logic             div_start_ex,
  input  logic             data_wait,
  input  logic             exc_flush,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             bubble_ex,
  output logic             stall_ex_mem,
  output logic             bubble_mem,
  output logic             flush_all,
  output logic             div_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic   h_bj_ex, h_bj_mem, h_lu, id_haz;
  state_t state, state_n, saved, saved_n, eff_state;
  logic [5:0] cnt, cnt_n;
  logic   div_act;

  hazard_detect u_hazard_detect (
    .bj_id            (bj_id),
    .use_id           (use_id),
    .r1_id            (r1_id),
    .r2_id            (r2_id),
    .rw_ex            (rw_ex),
    .rw_mem           (rw_mem),
    .reg_we_direct_ex (reg_we_direct_ex),
    .mem_read_ex      (mem_read_ex),
    .mem_read_mem     (mem_read_mem),
    .h_bj_ex          (h_bj_ex),
    .h_bj_mem         (h_bj_mem),
    .h_lu             (h_lu)
  );

  assign id_haz = h_bj_ex || h_bj_mem || h_lu;

  // MWAIT behaves as the state it interrupted once data_wait drops
  assign eff_state = (state == ST_MWAIT) ? saved : state;
  assign div_act   = (eff_state == ST_DIV) || ((eff_state == ST_IDLE) && div_start_ex);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      saved     <= ST_IDLE;
      cnt       <= 6'd0;
      stall_cnt <= '0;
    end else begin
      state <= state_n;
      saved <= saved_n;
      cnt   <= cnt_n;
      if (stall_pc && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_n = state;
    saved_n = saved;
    cnt_n   = cnt;
    if (exc_flush) begin
      state_n = ST_IDLE;
      saved_n = ST_IDLE;
      cnt_n   = 6'd0;
    end else if (data_wait) begin
      state_n = ST_MWAIT;
      saved_n = eff_state;
    end else begin
      case (eff_state)
        ST_DIV: begin
          // the issuing IDLE cycle already stalled once, so DIV lasts DIV_CYCLES-1
          cnt_n   = cnt - 6'd1;
          state_n = (cnt == 6'd1) ? ST_IDLE : ST_DIV;
        end
        default: begin
          if (div_start_ex) begin
            state_n = ST_DIV;
            cnt_n   = 6'(DIV_CYCLES - 1);
          end else begin
            state_n = ST_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    bubble_ex    = 1'b0;
    stall_ex_mem = 1'b0;
    bubble_mem   = 1'b0;
    flush_all    = 1'b0;
    div_busy     = 1'b0;
    if (!resetn || exc_flush) begin
      flush_all = 1'b1;
    end else begin
      div_busy = (eff_state == ST_DIV) || ((eff_state == ST_IDLE) && div_start_ex && !data_wait);
      if (data_wait) begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        stall_ex_mem = 1'b1;
      end else if (div_act) begin
        stall_pc    = 1'b1;
        stall_if_id = 1'b1;
        stall_id_ex = 1'b1;
        bubble_mem  = 1'b1;
      end else if (id_haz) begin
        stall_pc    = 1'b1;
        stall_if_id = 1'b1;
        bubble_ex   = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int DIVC = 33;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic [1:0]    bj_id, use_id;
  logic [4:0]    r1_id, r2_id, rw_ex, rw_mem;
  logic [3:0]    reg_we_direct_ex;
  logic          mem_read_ex, mem_read_mem, div_start_ex, data_wait, exc_flush;
  logic          stall_pc, stall_if_id, stall_id_ex, bubble_ex;
  logic          stall_ex_mem, bubble_mem, flush_all, div_busy;
  logic [CW-1:0] stall_cnt;

  int n_pass  = 0;
  int n_total = 0;
  int m_div_left = 0;
  int m_sc = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DIV_CYCLES(DIVC), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn), .bj_id(bj_id), .use_id(use_id),
    .r1_id(r1_id), .r2_id(r2_id), .rw_ex(rw_ex), .rw_mem(rw_mem),
    .reg_we_direct_ex(reg_we_direct_ex), .mem_read_ex(mem_read_ex),
    .mem_read_mem(mem_read_mem), .div_start_ex(div_start_ex),
    .data_wait(data_wait), .exc_flush(exc_flush),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
    .bubble_ex(bubble_ex), .stall_ex_mem(stall_ex_mem), .bubble_mem(bubble_mem),
    .flush_all(flush_all), .div_busy(div_busy), .stall_cnt(stall_cnt)
  );

  wire [7:0] dut_v = {stall_pc, stall_if_id, stall_id_ex, bubble_ex,
                      stall_ex_mem, bubble_mem, flush_all, div_busy};

  function automatic logic ref_haz();
    logic bj_ex, bj_mem, lu;
    bj_ex  = (rw_ex != 0) && (reg_we_direct_ex == 4'b0001) &&
             ((bj_id[0] && r1_id == rw_ex) || (bj_id[1] && r2_id == rw_ex));
    bj_mem = (rw_mem != 0) && mem_read_mem &&
             ((bj_id[0] && r1_id == rw_mem) || (bj_id[1] && r2_id == rw_mem));
    lu     = (rw_ex != 0) && mem_read_ex &&
             ((use_id[0] && r1_id == rw_ex) || (use_id[1] && r2_id == rw_ex));
    return bj_ex || bj_mem || lu;
  endfunction

  // {stall_pc, stall_if_id, stall_id_ex, bubble_ex, stall_ex_mem, bubble_mem, flush_all, div_busy}
  function automatic logic [7:0] exp_out();
    logic [7:0] v;
    v = 8'b0;
    if (!resetn || exc_flush) begin
      v = 8'b0000_0010;
    end else begin
      if (data_wait)                          v = 8'b1110_1000;
      else if (m_div_left > 0 || div_start_ex) v = 8'b1110_0100;
      else if (ref_haz())                     v = 8'b1101_0000;
      v[0] = (m_div_left > 0) || (div_start_ex && !data_wait);
    end
    return v;
  endfunction

  // advance the reference one clock, then move past the DUT edge
  task automatic tick();
    logic sp;
    sp = exp_out()[7];
    if (!resetn) begin
      m_div_left = 0;
      m_sc = 0;
    end else begin
      if (exc_flush) m_div_left = 0;
      else if (!data_wait && (m_div_left > 0 || div_start_ex)) begin
        if (m_div_left == 0) m_div_left = DIVC;
        m_div_left = m_div_left - 1;
      end
      if (sp && m_sc < (1 << CW) - 1) m_sc = m_sc + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bj_id = 0; use_id = 0; r1_id = 0; r2_id = 0; rw_ex = 0; rw_mem = 0;
    reg_we_direct_ex = 0; mem_read_ex = 0; mem_read_mem = 0;
    div_start_ex = 0; data_wait = 0; exc_flush = 0;
  endtask

  task automatic test_reset();
    quiet();
    resetn = 0;
    bj_id = 2'b01; r1_id = 5'd5; rw_ex = 5'd5; reg_we_direct_ex = 4'b0001;
    @(negedge clk);
    n_total++;
    if (dut_v !== 8'b0000_0010) $display("FAIL reset_outputs got %b want %b", dut_v, 8'b0000_0010);
    else n_pass++;
    tick();
    @(negedge clk);
    n_total++;
    if (stall_cnt !== 0) $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt);
    else n_pass++;
    tick();
    quiet();
    resetn = 1;
  endtask

  task automatic test_load_branch();
    quiet();
    rw_ex = 5'd3; mem_read_ex = 1; reg_we_direct_ex = 4'b0001; bj_id = 2'b01; r1_id = 5'd3; r2_id = 5'd4;
    @(negedge clk);
    n_total++;
    if ({stall_pc, bubble_ex} !== 2'b11) $display("FAIL lw_beq_c1 got %b want 11", {stall_pc, bubble_ex});
    else n_pass++;
    tick();
    rw_ex = 0; mem_read_ex = 0; reg_we_direct_ex = 0; rw_mem = 5'd3; mem_read_mem = 1;
    @(negedge clk);
    n_total++;
    if ({stall_pc, bubble_ex} !== 2'b11) $display("FAIL lw_beq_c2 got %b want 11", {stall_pc, bubble_ex});
    else n_pass++;
    tick();
    rw_mem = 0; mem_read_mem = 0;
    @(negedge clk);
    n_total++;
    if ({stall_pc, bubble_ex} !== 2'b00) $display("FAIL lw_beq_c3 got %b want 00", {stall_pc, bubble_ex});
    else n_pass++;
    tick();
  endtask

  task automatic test_alu_jr();
    quiet();
    rw_ex = 5'd5; reg_we_direct_ex = 4'b0001; bj_id = 2'b01; r1_id = 5'd5;
    @(negedge clk);
    n_total++;
    if (dut_v !== 8'b1101_0000) $display("FAIL addu_jr_c1 got %b want 11010000", dut_v);
    else n_pass++;
    tick();
    rw_ex = 0; reg_we_direct_ex = 0; rw_mem = 5'd5;
    @(negedge clk);
    n_total++;
    if (stall_pc !== 1'b0) $display("FAIL addu_jr_c2 got %b want 0", stall_pc);
    else n_pass++;
    tick();
    quiet();
    rw_ex = 5'd0; reg_we_direct_ex = 4'b0001; bj_id = 2'b01; r1_id = 5'd0;
    @(negedge clk);
    n_total++;
    if (stall_pc !== 1'b0) $display("FAIL zero_dest got %b want 0", stall_pc);
    else n_pass++;
    tick();
  endtask

  task automatic test_forward_cases();
    quiet();
    rw_ex = 5'd6; reg_we_direct_ex = 4'b0010; bj_id = 2'b01; r1_id = 5'd6;
    @(negedge clk);
    n_total++;
    if (stall_pc !== 1'b0) $display("FAIL mfhi_bne got %b want 0", stall_pc);
    else n_pass++;
    tick();
    quiet();
    rw_ex = 5'd7; mem_read_ex = 1; use_id = 2'b10; r2_id = 5'd7; r1_id = 5'd1;
    @(negedge clk);
    n_total++;
    if (dut_v !== 8'b1101_0000) $display("FAIL load_use_rt got %b want 11010000", dut_v);
    else n_pass++;
    tick();
    quiet();
  endtask

  task automatic test_div(input bit with_wait);
    int n_busy, n_idex, n_bmem;
    n_busy = 0; n_idex = 0; n_bmem = 0;
    quiet();
    for (int c = 0; c < 100; c++) begin
      div_start_ex = (c == 0);
      data_wait = with_wait && c >= 10 && c < 13;
      @(negedge clk);
      n_busy += int'(div_busy);
      n_idex += int'(stall_id_ex);
      n_bmem += int'(bubble_mem);
      tick();
    end
    quiet();
    n_total++;
    if (n_busy !== (with_wait ? DIVC + 3 : DIVC))
      $display("FAIL div_busy_cycles wait=%0d got %0d want %0d", with_wait, n_busy, with_wait ? DIVC + 3 : DIVC);
    else n_pass++;
    n_total++;
    if (n_idex !== (with_wait ? DIVC + 3 : DIVC))
      $display("FAIL div_stall_cycles wait=%0d got %0d want %0d", with_wait, n_idex, with_wait ? DIVC + 3 : DIVC);
    else n_pass++;
    n_total++;
    if (n_bmem !== DIVC) $display("FAIL div_bubble_mem wait=%0d got %0d want %0d", with_wait, n_bmem, DIVC);
    else n_pass++;
  endtask

  task automatic test_exc_flush();
    quiet();
    for (int c = 0; c < 10; c++) begin
      div_start_ex = (c == 0);
      @(negedge clk);
      tick();
    end
    div_start_ex = 0; exc_flush = 1;
    @(negedge clk);
    n_total++;
    if ({flush_all, stall_pc, stall_id_ex, bubble_mem} !== 4'b1000)
      $display("FAIL exc_flush_cycle got %b want 1000", {flush_all, stall_pc, stall_id_ex, bubble_mem});
    else n_pass++;
    tick();
    exc_flush = 0;
    @(negedge clk);
    n_total++;
    if ({div_busy, stall_pc, flush_all} !== 3'b000)
      $display("FAIL exc_after got %b want 000", {div_busy, stall_pc, flush_all});
    else n_pass++;
    tick();
    div_start_ex = 1;
    @(negedge clk);
    n_total++;
    if ({div_busy, stall_pc} !== 2'b11) $display("FAIL exc_restart got %b want 11", {div_busy, stall_pc});
    else n_pass++;
    tick();
    div_start_ex = 0;
    for (int c = 0; c < DIVC + 2; c++) tick();
  endtask

  task automatic test_stall_cnt();
    quiet();
    rw_ex = 5'd5; reg_we_direct_ex = 4'b0001; bj_id = 2'b01; r1_id = 5'd5;
    resetn = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_total++;
      if ({flush_all, stall_pc} !== 2'b10) $display("FAIL cnt_reset_out got %b want 10", {flush_all, stall_pc});
      else n_pass++;
      tick();
    end
    @(negedge clk);
    n_total++;
    if (stall_cnt !== 0) $display("FAIL cnt_reset_val got %0d want 0", stall_cnt);
    else n_pass++;
    resetn = 1;
    for (int c = 0; c < 5; c++) tick();
    @(negedge clk);
    n_total++;
    if (stall_cnt !== 5) $display("FAIL cnt_five got %0d want 5", stall_cnt);
    else n_pass++;
    for (int c = 0; c < 12; c++) tick();
    @(negedge clk);
    n_total++;
    if (stall_cnt !== 4'hF) $display("FAIL cnt_saturate got %0d want 15", stall_cnt);
    else n_pass++;
    quiet();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      resetn           = ($urandom_range(0, 99) >= 2);
      bj_id            = 2'($urandom_range(0, 3));
      use_id           = 2'($urandom_range(0, 3));
      r1_id            = 5'($urandom_range(0, 3));
      r2_id            = 5'($urandom_range(0, 3));
      rw_ex            = 5'($urandom_range(0, 3));
      rw_mem           = 5'($urandom_range(0, 3));
      reg_we_direct_ex = ($urandom_range(0, 4) == 4) ? 4'b0000 : 4'(1 << $urandom_range(0, 3));
      mem_read_ex      = 1'($urandom_range(0, 1));
      mem_read_mem     = 1'($urandom_range(0, 1));
      div_start_ex     = ($urandom_range(0, 99) < 5);
      data_wait        = ($urandom_range(0, 99) < 15);
      exc_flush        = ($urandom_range(0, 99) < 3);
      @(negedge clk);
      n_total++;
      if (dut_v !== exp_out()) $display("FAIL rand_outputs cycle %0d got %b want %b", c, dut_v, exp_out());
      else n_pass++;
      n_total++;
      if (stall_cnt !== CW'(m_sc)) $display("FAIL rand_stall_cnt cycle %0d got %0d want %0d", c, stall_cnt, m_sc);
      else n_pass++;
      tick();
    end
    quiet();
    resetn = 1;
  endtask

  initial begin
    test_reset();
    test_load_branch();
    test_alu_jr();
    test_forward_cases();
    test_div(1'b0);
    test_div(1'b1);
    test_exc_flush();
    test_stall_cnt();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
